// File: rtl/instr_encoder_if.sv
// Descriptor-in / word-out / error bundle of the instruction encoder.
// The encoder takes the slave side; the loader (or bench) takes the master side.
interface instr_encoder_if #(
   parameter int unsigned ADDR_WIDTH = 12
);
   logic                  in_valid;
   logic                  in_ready;
   logic [3:0]            in_kind;
   logic [3:0]            in_funct;
   logic [4:0]            in_rd;
   logic [4:0]            in_rs1;
   logic [4:0]            in_rs2;
   logic                  in_scalar;
   logic [31:0]           in_imm;
   logic                  out_valid;
   logic                  out_ready;
   logic [31:0]           out_instr;
   logic [ADDR_WIDTH-1:0] out_addr;
   logic                  err_valid;
   logic [2:0]            err_code;

   modport master (
      output in_valid, in_kind, in_funct, in_rd, in_rs1, in_rs2, in_scalar, in_imm, out_ready,
      input  in_ready, out_valid, out_instr, out_addr, err_valid, err_code
   );

   modport slave (
      input  in_valid, in_kind, in_funct, in_rd, in_rs1, in_rs2, in_scalar, in_imm, out_ready,
      output in_ready, out_valid, out_instr, out_addr, err_valid, err_code
   );
endinterface

// File: rtl/instr_encoder.sv
// Packs operation descriptors into 32-bit machine words for the program loader.
// LI expands to LUI+ADDI when the immediate does not fit the 14-bit ADDI field.
module instr_encoder #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned BASE_ADDR  = 0
) (
   input logic            clk,
   input logic            reset,
   instr_encoder_if.slave bus
);
   localparam logic [2:0] OpR = 3'd0, OpI = 3'd1, OpF = 3'd2, OpM = 3'd3, OpUp = 3'd4, OpJ = 3'd5;

   localparam logic [3:0] KindR = 4'd0, KindI = 4'd1, KindF = 4'd2, KindLw = 4'd3, KindSw = 4'd4;
   localparam logic [3:0] KindFlw = 4'd5, KindFsw = 4'd6, KindLui = 4'd7, KindJal = 4'd8;
   localparam logic [3:0] KindBr = 4'd9, KindSync = 4'd10, KindExit = 4'd11, KindLi = 4'd12;

   localparam logic [2:0] ErrNone = 3'd0, ErrBadKind = 3'd1, ErrBadFunct = 3'd2;
   localparam logic [2:0] ErrImmRange = 3'd3, ErrMisaligned = 3'd4;

   typedef enum logic [1:0] {StIdle, StHold, StHold2} state_e;

   state_e                state_q;
   logic                  out_valid_q;
   logic [31:0]           out_instr_q;
   logic [31:0]           pend_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  err_valid_q;
   logic [2:0]            err_code_q;

   logic [31:0] imm;
   logic [3:0]  funct;
   logic [4:0]  rd, rs1, rs2;
   logic        sc;
   logic [19:0] li_hi;
   logic [13:0] li_lo;
   logic [31:0] word0, word1;
   logic        two_words;
   logic [2:0]  code;
   logic        accept;

   function automatic logic fits_signed(logic [31:0] v, int unsigned n);
      logic [31:0] t;
      t = 32'($signed(v) >>> (n - 1));
      return (t == '0) || (t == '1);
   endfunction

   assign imm    = bus.in_imm;
   assign funct  = bus.in_funct;
   assign rd     = bus.in_rd;
   assign rs1    = bus.in_rs1;
   assign rs2    = bus.in_rs2;
   assign sc     = bus.in_scalar;
   assign accept = bus.in_valid && bus.in_ready;

   // LI split: hi rounds so that lo lands in [-2048, 2047]; lo only needs 14 bits.
   assign li_hi = 20'((imm + 32'h0000_0800) >> 12);
   assign li_lo = imm[13:0] - {li_hi[1:0], 12'h000};

   always_comb begin
      word0     = '0;
      word1     = '0;
      two_words = 1'b0;
      code      = ErrNone;
      case (bus.in_kind)
         KindR: begin
            if (funct > 4'd9) code = ErrBadFunct;
            word0 = {OpR, sc, 9'b0, rs2, funct, rs1, rd};
         end
         KindI: begin
            if (!(funct inside {4'd0, 4'd2, 4'd3, 4'd10})) code = ErrBadFunct;
            else if (!fits_signed(imm, 14)) code = ErrImmRange;
            word0 = {OpI, sc, imm[13:0], funct, rs1, rd};
         end
         KindF: begin
            if (funct > 4'd10) code = ErrBadFunct;
            word0 = {OpF, sc, 9'b0, rs2, funct, rs1, rd};
         end
         KindLw, KindFlw: begin
            if (!fits_signed(imm, 15)) code = ErrImmRange;
            word0 = {OpM, imm[14:0], sc, (bus.in_kind == KindLw) ? 3'b000 : 3'b010, rs1, rd};
         end
         KindSw, KindFsw: begin
            if (!fits_signed(imm, 15)) code = ErrImmRange;
            word0 = {OpM, imm[14:5], rs2, sc, (bus.in_kind == KindSw) ? 3'b001 : 3'b011, rs1,
                     imm[4:0]};
         end
         KindLui: begin
            if (imm[11:0] != 12'h000) code = ErrImmRange;
            word0 = {OpUp, imm[31:12], 3'b000, sc, rd};
         end
         KindJal: begin
            if (imm[1:0] != 2'b00) code = ErrMisaligned;
            else if (!fits_signed(imm, 28)) code = ErrImmRange;
            word0 = {OpJ, imm[27:12], 3'b000, imm[11:2]};
         end
         KindBr: begin
            if (imm[1:0] != 2'b00) code = ErrMisaligned;
            else if (!fits_signed(imm, 18)) code = ErrImmRange;
            word0 = {OpJ, imm[17:8], rs2, imm[7], 3'b001, rs1, imm[6:2]};
         end
         KindSync: word0 = {OpJ, 16'b0, 3'b110, 10'b0};
         KindExit: word0 = {OpJ, 16'b0, 3'b111, 10'b0};
         KindLi: begin
            if (fits_signed(imm, 14)) begin
               word0 = {OpI, sc, imm[13:0], 4'b0000, 5'd0, rd};
            end else begin
               two_words = 1'b1;
               word0     = {OpUp, li_hi, 3'b000, sc, rd};
               word1     = {OpI, sc, li_lo, 4'b0000, rd, rd};
            end
         end
         default: code = ErrBadKind;
      endcase
   end

   assign bus.in_ready = (state_q == StIdle) || ((state_q == StHold) && bus.out_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         pend_q      <= '0;
         addr_q      <= ADDR_WIDTH'(BASE_ADDR);
         err_valid_q <= 1'b0;
         err_code_q  <= ErrNone;
      end else begin
         err_valid_q <= 1'b0;
         if (out_valid_q && bus.out_ready) begin
            addr_q <= addr_q + 1'b1;
            if (state_q == StHold2) begin
               out_instr_q <= pend_q;
               state_q     <= StHold;
            end else begin
               out_valid_q <= 1'b0;
               state_q     <= StIdle;
            end
         end
         // Acceptance overrides the HOLD->IDLE drop above (back-to-back streaming).
         if (accept) begin
            if (code != ErrNone) begin
               err_valid_q <= 1'b1;
               err_code_q  <= code;
            end else begin
               out_valid_q <= 1'b1;
               out_instr_q <= word0;
               pend_q      <= word1;
               state_q     <= two_words ? StHold2 : StHold;
            end
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_instr = out_instr_q;
   assign bus.out_addr  = addr_q;
   assign bus.err_valid = err_valid_q;
   assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized scoreboard bench for instr_encoder: a field-level reference model predicts
// words, addresses and error codes; a negedge monitor compares what the DUT presents.
module tb_instr_encoder;
   localparam int unsigned AW   = 12;
   localparam int unsigned BASE = 0;
   localparam longint OP_R = 0, OP_I = 1, OP_F = 2, OP_M = 3, OP_UP = 4, OP_J = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   instr_encoder_if #(.ADDR_WIDTH(AW)) bus ();
   instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int failures = 0;
   logic [31:0]   exp_instr_q[$];
   logic [AW-1:0] exp_addr_q[$];
   logic [2:0]    exp_err_q[$];
   logic [AW-1:0] next_addr = AW'(BASE);
   logic [2:0]    last_code = 3'd0;
   bit            rand_ready = 1'b0;

   int edge_imm[20] = '{8191, 8192, -8192, -8193, 16383, 16384, -16384, -16385, 131068, 131072,
                        -131072, -131076, 32'h07FF_FFFC, 32'h0800_0000, 32'hF800_0000,
                        32'hF7FF_FFFC, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0001_2800, 2046};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   // Field placement helper: low 'width' bits of v shifted to 'lsb'.
   function automatic longint fld(input longint v, input int lsb, input int width);
      return (v & ((longint'(1) << width) - 1)) << lsb;
   endfunction

   function automatic bit fits(input longint v, input int n);
      return (v >= -(longint'(1) << (n - 1))) && (v < (longint'(1) << (n - 1)));
   endfunction

   function automatic void model(input logic [3:0] kind, input logic [3:0] funct,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic sc,
                                 input logic [31:0] imm_bits, output logic [2:0] code,
                                 output int nw, output logic [31:0] w0, output logic [31:0] w1);
      longint imm = longint'($signed(imm_bits));
      longint base_r = fld(rs1, 5, 5) + fld(rd, 0, 5);
      longint q = imm >>> 2;
      longint hi, lo, w = 0;
      code = 0;
      nw   = 1;
      w1   = '0;
      case (kind)
         0, 2: begin
            if (funct > ((kind == 0) ? 9 : 10)) code = 2;
            w = fld((kind == 0) ? OP_R : OP_F, 29, 3) + fld(sc, 28, 1) + fld(rs2, 14, 5)
              + fld(funct, 10, 4) + base_r;
         end
         1: begin
            if (!(funct == 0 || funct == 2 || funct == 3 || funct == 10)) code = 2;
            else if (!fits(imm, 14)) code = 3;
            w = fld(OP_I, 29, 3) + fld(sc, 28, 1) + fld(imm, 14, 14) + fld(funct, 10, 4) + base_r;
         end
         3, 5: begin
            if (!fits(imm, 15)) code = 3;
            w = fld(OP_M, 29, 3) + fld(imm, 14, 15) + fld(sc, 13, 1)
              + fld((kind == 3) ? 0 : 2, 10, 3) + base_r;
         end
         4, 6: begin
            if (!fits(imm, 15)) code = 3;
            w = fld(OP_M, 29, 3) + fld(imm >>> 5, 19, 10) + fld(rs2, 14, 5) + fld(sc, 13, 1)
              + fld((kind == 4) ? 1 : 3, 10, 3) + fld(rs1, 5, 5) + fld(imm, 0, 5);
         end
         7: begin
            if ((imm % 4096) != 0) code = 3;
            w = fld(OP_UP, 29, 3) + fld(imm >>> 12, 9, 20) + fld(sc, 5, 1) + fld(rd, 0, 5);
         end
         8: begin
            if ((imm & 3) != 0) code = 4;
            else if (!fits(imm, 28)) code = 3;
            w = fld(OP_J, 29, 3) + fld(q >>> 10, 13, 16) + fld(q, 0, 10);
         end
         9: begin
            if ((imm & 3) != 0) code = 4;
            else if (!fits(imm, 18)) code = 3;
            w = fld(OP_J, 29, 3) + fld(q >>> 6, 19, 10) + fld(rs2, 14, 5) + fld(q >>> 5, 13, 1)
              + fld(1, 10, 3) + fld(rs1, 5, 5) + fld(q, 0, 5);
         end
         10, 11: w = fld(OP_J, 29, 3) + fld((kind == 10) ? 6 : 7, 10, 3);
         12: begin
            if (fits(imm, 14)) begin
               w = fld(OP_I, 29, 3) + fld(sc, 28, 1) + fld(imm, 14, 14) + fld(rd, 0, 5);
            end else begin
               nw = 2;
               hi = (imm + 2048) >>> 12;
               lo = imm - hi * 4096;
               w  = fld(OP_UP, 29, 3) + fld(hi, 9, 20) + fld(sc, 5, 1) + fld(rd, 0, 5);
               w1 = 32'(fld(OP_I, 29, 3) + fld(sc, 28, 1) + fld(lo, 14, 14) + fld(rd, 5, 5)
                      + fld(rd, 0, 5));
            end
         end
         default: code = 1;
      endcase
      w0 = 32'(w);
      if (code != 0) nw = 0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_expected();
      logic [2:0] code;
      int nw;
      logic [31:0] w0, w1;
      model(bus.in_kind, bus.in_funct, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_scalar,
            bus.in_imm, code, nw, w0, w1);
      if (code != 0) exp_err_q.push_back(code);
      if (nw >= 1) begin
         exp_instr_q.push_back(w0);
         exp_addr_q.push_back(next_addr);
         next_addr++;
      end
      if (nw == 2) begin
         exp_instr_q.push_back(w1);
         exp_addr_q.push_back(next_addr);
         next_addr++;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input logic [3:0] kind, input logic [3:0] funct, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic sc,
                       input logic [31:0] imm);
      bus.in_kind   = kind;
      bus.in_funct  = funct;
      bus.in_rd     = rd;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.in_scalar = sc;
      bus.in_imm    = imm;
      bus.in_valid  = 1'b1;
      for (int t = 0; t < 64; t++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            push_expected();
            step();
            bus.in_valid = 1'b0;
            return;
         end
         step();
      end
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no in_ready, required acceptance within 64 cycles");
      bus.in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      exp_instr_q.delete();
      exp_addr_q.delete();
      exp_err_q.delete();
      next_addr = AW'(BASE);
      last_code = 3'd0;
      reset     = 1'b0;
   endtask

   task automatic rand_desc(output logic [3:0] kind, output logic [3:0] funct,
                            output logic [4:0] rd, output logic [4:0] rs1, output logic [4:0] rs2,
                            output logic sc, output logic [31:0] imm);
      logic [31:0] r;
      kind  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 12));
      funct = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      rd    = 5'($urandom);
      rs1   = 5'($urandom);
      rs2   = 5'($urandom);
      sc    = 1'($urandom);
      r     = $urandom;
      if ($urandom_range(0, 3) == 0) imm = edge_imm[$urandom_range(0, 19)];
      else imm = 32'($signed(r) >>> $urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) imm[1:0] = 2'b00;
      if (kind == 4'd7 && $urandom_range(0, 2) != 0) imm[11:0] = 12'h000;
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: compares presented words (and their stability while stalled) and error pulses.
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         if (bus.out_valid) begin
            if (exp_instr_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_word: got 0x%08h, required no word", bus.out_instr);
            end else begin
               check("sb_out_instr", bus.out_instr, exp_instr_q[0]);
               check("sb_out_addr", 32'(bus.out_addr), 32'(exp_addr_q[0]));
               if (bus.out_ready) begin
                  void'(exp_instr_q.pop_front());
                  void'(exp_addr_q.pop_front());
               end
            end
         end
         if (bus.err_valid) begin
            if (exp_err_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_err: got code %0d, required no error", bus.err_code);
            end else begin
               last_code = exp_err_q.pop_front();
               check("sb_err_code", 32'(bus.err_code), 32'(last_code));
            end
         end else begin
            check("err_code_hold", 32'(bus.err_code), 32'(last_code));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required completion within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0]  k, f;
      logic [4:0]  rd, rs1, rs2;
      logic        sc;
      logic [31:0] imm;

      bus.in_valid  = 1'b0;
      bus.in_kind   = '0;
      bus.in_funct  = '0;
      bus.in_rd     = '0;
      bus.in_rs1    = '0;
      bus.in_rs2    = '0;
      bus.in_scalar = 1'b0;
      bus.in_imm    = '0;
      bus.out_ready = 1'b1;
      do_reset();

      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_instr", bus.out_instr, 32'd0);
      check("rst_out_addr", 32'(bus.out_addr), BASE);
      check("rst_err_valid", 32'(bus.err_valid), 32'd0);
      check("rst_err_code", 32'(bus.err_code), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);

      step();
      send(4'd0, 4'd0, 5'd3, 5'd1, 5'd2, 1'b0, 32'd0);
      @(negedge clk);
      check("add_latency", 32'(bus.out_valid), 32'd1);
      check("add_word", bus.out_instr, {3'(OP_R), 29'h0000_8023});
      check("add_addr", 32'(bus.out_addr), 32'd0);

      do_reset();
      send(4'd12, 4'd0, 5'd5, 5'd0, 5'd0, 1'b0, 32'h1234_5678);
      @(negedge clk);
      check("li_lui_word", bus.out_instr, {3'(OP_UP), 29'h0246_8A05});
      check("li_lui_addr", 32'(bus.out_addr), 32'd0);
      check("li_hold2_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      check("li_addi_word", bus.out_instr, {3'(OP_I), 29'h019E_00A5});
      check("li_addi_addr", 32'(bus.out_addr), 32'd1);

      step();
      send(4'd12, 4'd0, 5'd7, 5'd0, 5'd0, 1'b0, 32'h0001_2800);
      @(negedge clk);
      check("li_neg_lo_lui", bus.out_instr, {3'(OP_UP), 29'h0000_2607});
      @(negedge clk);
      check("li_neg_lo_addi", bus.out_instr, {3'(OP_I), 29'h0E00_00E7});

      step();
      send(4'd9, 4'd0, 5'd0, 5'd4, 5'd6, 1'b0, -32'sd8);
      @(negedge clk);
      check("br_word", bus.out_instr, {3'(OP_J), 29'h1FF9_A49E});
      check("br_addr", 32'(bus.out_addr), 32'd4);
      step();
      send(4'd9, 4'd0, 5'd0, 5'd4, 5'd6, 1'b0, -32'sd6);
      @(negedge clk);
      check("br_misaligned_pulse", 32'(bus.err_valid), 32'd1);
      check("br_misaligned_code", 32'(bus.err_code), 32'd4);
      check("br_misaligned_noword", 32'(bus.out_valid), 32'd0);

      step();
      send(4'd1, 4'd0, 5'd1, 5'd2, 5'd0, 1'b0, 32'd9000);
      @(negedge clk);
      check("addi_range_pulse", 32'(bus.err_valid), 32'd1);
      check("addi_range_code", 32'(bus.err_code), 32'd3);
      check("addi_range_addr", 32'(bus.out_addr), 32'd5);
      @(negedge clk);
      check("addi_range_pulse_end", 32'(bus.err_valid), 32'd0);
      step();
      send(4'd14, 4'd0, 5'd1, 5'd2, 5'd3, 1'b0, 32'd0);
      @(negedge clk);
      check("bad_kind_code", 32'(bus.err_code), 32'd1);

      bus.out_ready = 1'b0;
      step();
      send(4'd12, 4'd0, 5'd5, 5'd0, 5'd0, 1'b0, 32'h1234_5678);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_valid", 32'(bus.out_valid), 32'd1);
         check("stall_word", bus.out_instr, {3'(OP_UP), 29'h0246_8A05});
         check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      end
      step();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("hold2_rst_valid", 32'(bus.out_valid), 32'd0);
      check("hold2_rst_addr", 32'(bus.out_addr), BASE);
      do_reset();

      rand_ready = 1'b1;
      for (int n = 0; n < 400; n++) begin
         rand_desc(k, f, rd, rs1, rs2, sc, imm);
         send(k, f, rd, rs1, rs2, sc, imm);
         if ($urandom_range(0, 3) == 0) step();
      end

      rand_ready    = 1'b0;
      bus.out_ready = 1'b1;
      for (int t = 0; t < 100 && (exp_instr_q.size() != 0 || exp_err_q.size() != 0); t++)
         @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      check("drain_words", 32'(exp_instr_q.size()), 32'd0);
      check("drain_errs", 32'(exp_err_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
